// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - fetch stage control, redirect, inst_mem and IF/ID signals
interface fetch_stage_if;
   logic        stall_i;
   logic        flush_i;
   logic        halt_i;
   logic [1:0]  pc_src_i;
   logic [31:0] branch_target_i;
   logic [25:0] jump_index_i;
   logic [31:0] jr_target_i;
   logic [31:0] imem_rd_i;
   logic [31:0] imem_a_o;
   logic [31:0] ifid_instr_o;
   logic [31:0] ifid_pc4_o;
   logic        ifid_valid_o;
   logic        halted_o;
   logic        misalign_o;
   logic [31:0] fetch_cnt_o;

   modport master (
      input  stall_i, flush_i, halt_i, pc_src_i, branch_target_i, jump_index_i,
             jr_target_i, imem_rd_i,
      output imem_a_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, halted_o,
             misalign_o, fetch_cnt_o
   );

   modport slave (
      output stall_i, flush_i, halt_i, pc_src_i, branch_target_i, jump_index_i,
             jr_target_i, imem_rd_i,
      input  imem_a_o, ifid_instr_o, ifid_pc4_o, ifid_valid_o, halted_o,
             misalign_o, fetch_cnt_o
   );
endinterface

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MCU instruction fetch: PC, next-PC select, IF/ID register, halt FSM
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           reset,
   fetch_stage_if.master  bus
);

   typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] pc4_q, pc4_d;
   logic [31:0] cnt_q, cnt_d;
   logic        valid_q, valid_d;
   logic        mis_q, mis_d;
   logic [31:0] pc_plus4;

   assign pc_plus4 = pc_q + 32'd4;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         pc_q    <= RESET_PC;
         instr_q <= NOP_WORD;
         pc4_q   <= 32'd0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         cnt_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         pc4_q   <= pc4_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      pc4_d   = pc4_q;
      valid_d = valid_q;
      mis_d   = mis_q;
      cnt_d   = cnt_q;
      if (state_q == HALT) begin
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else if (bus.halt_i && !bus.stall_i) begin
         // The halting edge already behaves as HALT: PC and counter freeze, IF/ID becomes a bubble.
         state_d = HALT;
         instr_d = NOP_WORD;
         valid_d = 1'b0;
      end else begin
         if (!bus.stall_i) begin
            case (bus.pc_src_i)
               2'b01: begin
                  pc_d = {bus.branch_target_i[31:2], 2'b00};
                  if (bus.branch_target_i[1:0] != 2'b00) mis_d = 1'b1;
               end
               2'b10: pc_d = {pc4_q[31:28], bus.jump_index_i, 2'b00};
               2'b11: begin
                  pc_d = {bus.jr_target_i[31:2], 2'b00};
                  if (bus.jr_target_i[1:0] != 2'b00) mis_d = 1'b1;
               end
               default: pc_d = pc_plus4;
            endcase
         end
         // Flush beats stall so a squashed slot never lingers in IF/ID.
         if (bus.flush_i) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
         end else if (!bus.stall_i) begin
            instr_d = bus.imem_rd_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
         end
      end
   end

   assign bus.imem_a_o     = pc_q;
   assign bus.ifid_instr_o = instr_q;
   assign bus.ifid_pc4_o   = pc4_q;
   assign bus.ifid_valid_o = valid_q;
   assign bus.halted_o     = (state_q == HALT);
   assign bus.misalign_o   = mis_q;
   assign bus.fetch_cnt_o  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   logic [31:0] rom [0:63];

   fetch_stage_if bus ();

   fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   assign bus.imem_rd_i = rom[bus.imem_a_o[7:2]];

   function automatic logic [31:0] romval(input int i);
      return 32'hCAFE_0000 + 32'(i);
   endfunction

   task automatic clear_inputs;
      bus.stall_i = 1'b0; bus.flush_i = 1'b0; bus.halt_i = 1'b0; bus.pc_src_i = 2'b00;
      bus.branch_target_i = 32'd0; bus.jump_index_i = 26'd0; bus.jr_target_i = 32'd0;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      clear_inputs();
      reset = 1'b1;
      #2;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      clear_inputs();
      reset = 1'b1;
      #2;
      vectors++; if (bus.imem_a_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc actual=%h required=%h", bus.imem_a_o, 32'h0); end
      vectors++; if (bus.ifid_instr_o !== 32'h0) begin miscompares++; $display("FAIL reset_instr actual=%h required=%h", bus.ifid_instr_o, 32'h0); end
      vectors++; if (bus.ifid_pc4_o !== 32'h0) begin miscompares++; $display("FAIL reset_pc4 actual=%h required=%h", bus.ifid_pc4_o, 32'h0); end
      vectors++; if ({bus.ifid_valid_o, bus.halted_o, bus.misalign_o} !== 3'b000) begin miscompares++; $display("FAIL reset_flags actual=%b required=000", {bus.ifid_valid_o, bus.halted_o, bus.misalign_o}); end
      vectors++; if (bus.fetch_cnt_o !== 32'd0) begin miscompares++; $display("FAIL reset_cnt actual=%0d required=0", bus.fetch_cnt_o); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_sequential;
      for (int k = 1; k <= 4; k++) begin
         tick();
         vectors++; if (bus.imem_a_o !== 32'(4 * k)) begin miscompares++; $display("FAIL seq_pc[%0d] actual=%h required=%h", k, bus.imem_a_o, 32'(4 * k)); end
         vectors++; if (bus.ifid_instr_o !== romval(k - 1) || bus.ifid_valid_o !== 1'b1) begin miscompares++; $display("FAIL seq_instr[%0d] actual=%h/%b required=%h/1", k, bus.ifid_instr_o, bus.ifid_valid_o, romval(k - 1)); end
         vectors++; if (bus.ifid_pc4_o !== 32'(4 * k)) begin miscompares++; $display("FAIL seq_pc4[%0d] actual=%h required=%h", k, bus.ifid_pc4_o, 32'(4 * k)); end
         vectors++; if (bus.fetch_cnt_o !== 32'(k)) begin miscompares++; $display("FAIL seq_cnt[%0d] actual=%0d required=%0d", k, bus.fetch_cnt_o, k); end
      end
   endtask

   task automatic test_stall;
      do_reset();
      tick(); tick();
      bus.stall_i = 1'b1;
      bus.pc_src_i = 2'b01; bus.branch_target_i = 32'h0000_0080;
      for (int k = 0; k < 2; k++) begin
         tick();
         vectors++; if (bus.imem_a_o !== 32'h8) begin miscompares++; $display("FAIL stall_pc[%0d] actual=%h required=%h", k, bus.imem_a_o, 32'h8); end
         vectors++; if (bus.ifid_instr_o !== romval(1) || bus.ifid_valid_o !== 1'b1) begin miscompares++; $display("FAIL stall_hold[%0d] actual=%h required=%h", k, bus.ifid_instr_o, romval(1)); end
         vectors++; if (bus.fetch_cnt_o !== 32'd2) begin miscompares++; $display("FAIL stall_cnt[%0d] actual=%0d required=2", k, bus.fetch_cnt_o); end
      end
      clear_inputs();
      tick();
      vectors++; if (bus.ifid_instr_o !== romval(2) || bus.imem_a_o !== 32'hC) begin miscompares++; $display("FAIL stall_resume actual=%h@%h required=%h@%h", bus.ifid_instr_o, bus.imem_a_o, romval(2), 32'hC); end
      vectors++; if (bus.fetch_cnt_o !== 32'd3) begin miscompares++; $display("FAIL stall_resume_cnt actual=%0d required=3", bus.fetch_cnt_o); end
   endtask

   task automatic test_branch_flush;
      bus.pc_src_i = 2'b01; bus.branch_target_i = 32'h0000_0040; bus.flush_i = 1'b1;
      tick();
      vectors++; if (bus.imem_a_o !== 32'h40) begin miscompares++; $display("FAIL br_pc actual=%h required=%h", bus.imem_a_o, 32'h40); end
      vectors++; if (bus.ifid_valid_o !== 1'b0 || bus.ifid_instr_o !== 32'h0) begin miscompares++; $display("FAIL br_flush actual=%b/%h required=0/00000000", bus.ifid_valid_o, bus.ifid_instr_o); end
      vectors++; if (bus.ifid_pc4_o !== 32'hC || bus.fetch_cnt_o !== 32'd3) begin miscompares++; $display("FAIL br_flush_hold actual=%h/%0d required=0000000c/3", bus.ifid_pc4_o, bus.fetch_cnt_o); end
      clear_inputs();
      tick();
      vectors++; if (bus.ifid_instr_o !== romval(16) || bus.ifid_valid_o !== 1'b1) begin miscompares++; $display("FAIL br_target_word actual=%h required=%h", bus.ifid_instr_o, romval(16)); end
      vectors++; if (bus.ifid_pc4_o !== 32'h44 || bus.imem_a_o !== 32'h44) begin miscompares++; $display("FAIL br_after actual=%h/%h required=00000044/00000044", bus.ifid_pc4_o, bus.imem_a_o); end
   endtask

   task automatic test_jump_jr;
      do_reset();
      tick(); tick();
      bus.pc_src_i = 2'b10; bus.jump_index_i = 26'h10;
      tick();
      vectors++; if (bus.imem_a_o !== 32'h40) begin miscompares++; $display("FAIL jump_pc actual=%h required=%h", bus.imem_a_o, 32'h40); end
      vectors++; if (bus.ifid_instr_o !== romval(2) || bus.ifid_valid_o !== 1'b1) begin miscompares++; $display("FAIL jump_slot actual=%h required=%h", bus.ifid_instr_o, romval(2)); end
      vectors++; if (bus.misalign_o !== 1'b0) begin miscompares++; $display("FAIL jump_misalign actual=%b required=0", bus.misalign_o); end
      bus.pc_src_i = 2'b11; bus.jr_target_i = 32'h0000_0022;
      tick();
      vectors++; if (bus.imem_a_o !== 32'h20 || bus.misalign_o !== 1'b1) begin miscompares++; $display("FAIL jr_pc actual=%h/%b required=00000020/1", bus.imem_a_o, bus.misalign_o); end
      clear_inputs();
      tick();
      vectors++; if (bus.imem_a_o !== 32'h24 || bus.misalign_o !== 1'b1) begin miscompares++; $display("FAIL jr_sticky actual=%h/%b required=00000024/1", bus.imem_a_o, bus.misalign_o); end
      vectors++; if (bus.ifid_instr_o !== romval(8) || bus.fetch_cnt_o !== 32'd5) begin miscompares++; $display("FAIL jr_word actual=%h/%0d required=%h/5", bus.ifid_instr_o, bus.fetch_cnt_o, romval(8)); end
   endtask

   task automatic test_halt;
      do_reset();
      tick(); tick(); tick();
      bus.halt_i = 1'b1; bus.stall_i = 1'b1;
      tick();
      vectors++; if (bus.halted_o !== 1'b0 || bus.imem_a_o !== 32'hC) begin miscompares++; $display("FAIL halt_stall actual=%b/%h required=0/0000000c", bus.halted_o, bus.imem_a_o); end
      bus.stall_i = 1'b0;
      tick();
      vectors++; if (bus.halted_o !== 1'b1 || bus.imem_a_o !== 32'hC) begin miscompares++; $display("FAIL halt_enter actual=%b/%h required=1/0000000c", bus.halted_o, bus.imem_a_o); end
      clear_inputs();
      bus.pc_src_i = 2'b01; bus.branch_target_i = 32'h0000_0081;
      for (int k = 0; k < 10; k++) begin
         tick();
         vectors++; if (bus.halted_o !== 1'b1 || bus.imem_a_o !== 32'hC || bus.ifid_valid_o !== 1'b0 || bus.ifid_instr_o !== 32'h0 || bus.fetch_cnt_o !== 32'd3 || bus.misalign_o !== 1'b0) begin
            miscompares++; $display("FAIL halt_hold[%0d] actual=%b/%h/%b/%h/%0d/%b required=1/0000000c/0/00000000/3/0", k, bus.halted_o, bus.imem_a_o, bus.ifid_valid_o, bus.ifid_instr_o, bus.fetch_cnt_o, bus.misalign_o);
         end
      end
      do_reset();
      vectors++; if (bus.halted_o !== 1'b0 || bus.imem_a_o !== 32'h0) begin miscompares++; $display("FAIL halt_reset actual=%b/%h required=0/00000000", bus.halted_o, bus.imem_a_o); end
      tick();
      vectors++; if (bus.imem_a_o !== 32'h4 || bus.ifid_valid_o !== 1'b1) begin miscompares++; $display("FAIL halt_rerun actual=%h/%b required=00000004/1", bus.imem_a_o, bus.ifid_valid_o); end
   endtask

   task automatic test_wrap_async;
      do_reset();
      bus.pc_src_i = 2'b01; bus.branch_target_i = 32'hFFFF_FFFE;
      tick();
      vectors++; if (bus.imem_a_o !== 32'hFFFF_FFFC || bus.misalign_o !== 1'b1) begin miscompares++; $display("FAIL wrap_redirect actual=%h/%b required=fffffffc/1", bus.imem_a_o, bus.misalign_o); end
      clear_inputs();
      tick();
      vectors++; if (bus.imem_a_o !== 32'h0 || bus.ifid_pc4_o !== 32'h0) begin miscompares++; $display("FAIL wrap_pc actual=%h/%h required=00000000/00000000", bus.imem_a_o, bus.ifid_pc4_o); end
      vectors++; if (bus.ifid_instr_o !== romval(63) || bus.fetch_cnt_o !== 32'd2) begin miscompares++; $display("FAIL wrap_word actual=%h/%0d required=%h/2", bus.ifid_instr_o, bus.fetch_cnt_o, romval(63)); end
      tick();
      #2;
      reset = 1'b1;
      #1;
      vectors++; if (bus.imem_a_o !== 32'h0 || bus.ifid_instr_o !== 32'h0 || bus.ifid_pc4_o !== 32'h0) begin miscompares++; $display("FAIL async_data actual=%h/%h/%h required=0/0/0", bus.imem_a_o, bus.ifid_instr_o, bus.ifid_pc4_o); end
      vectors++; if ({bus.ifid_valid_o, bus.halted_o, bus.misalign_o} !== 3'b000 || bus.fetch_cnt_o !== 32'd0) begin miscompares++; $display("FAIL async_flags actual=%b/%0d required=000/0", {bus.ifid_valid_o, bus.halted_o, bus.misalign_o}, bus.fetch_cnt_o); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = romval(i);
      test_reset();
      test_sequential();
      test_stall();
      test_branch_flush();
      test_jump_jr();
      test_halt();
      test_wrap_async();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
